nqueens_cfu: RTL and testbench
==============================

NQUEENS_CFU -- requirements
Module: nqueens_cfu

Interface
REQ-001 SHALL have parameter MAX_N, default 16, maximum board size (legal range 4..31).
REQ-002 SHALL have parameter CNT_W, default 32, width of the solution and step counters.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_payload_function_id, input, 10, operation select.
REQ-008 SHALL have ports cmd_payload_inputs_0 and cmd_payload_inputs_1, input, 32 each, operands.
REQ-009 SHALL have port rsp_valid, output, 1, response held.
REQ-010 SHALL have port rsp_ready, input, 1, response consumed when high with rsp_valid.
REQ-011 SHALL have port rsp_payload_outputs_0, output, 32, result word.

Function
REQ-012 SHALL implement three states: IDLE, RUN, RESP; cmd_ready=1 only in IDLE.
REQ-013 SHALL register every response: accepted command -> RESP (or RUN), rsp_valid=1 from the next cycle, payload stable until rsp_ready; then IDLE.
REQ-014 SHALL decode function IDs: 0 INIT, 1 STEP, 2 GET_COUNT, 3 RUN, 4 GET_STATUS, 5 GET_STEPS; any other ID responds 0xFFFFFFFF, no state change.
REQ-015 INIT SHALL take n=inputs_0; if 1<=n<=MAX_N: level h=0, col[0]=(1<<n)-1, pos[0]=neg[0]=0, r=inputs_1&col[0] (all n columns if that is 0), count=0, steps=0, done=0, err=0; response 0.
REQ-016 INIT with n=0 or n>MAX_N SHALL set err=1, done=1, leave counters 0, respond 0xFFFFFFFF.
REQ-017 A kernel step with r!=0 SHALL: lsb=r&-r; cdt[h]=r&~lsb; col[h+1]=col[h]&~lsb; pos[h+1]=((pos[h]|lsb)<<1) masked to n bits; neg[h+1]=(neg[h]|lsb)>>1; r=col[h+1]&~(pos[h+1]|neg[h+1]); h=h+1.
REQ-018 A kernel step with r==0 SHALL: increment count if h==n (saturating at all-ones); if h==0 set done=1; else r=cdt[h-1], h=h-1 -- count and pop in the same cycle.
REQ-019 Every kernel step SHALL increment steps (saturating); no step SHALL execute when done=1.
REQ-020 STEP SHALL perform one kernel step and respond 1 if done=0 afterwards, else 0; STEP while done=1 responds 0 with no change.
REQ-021 RUN SHALL enter RUN, execute one kernel step per cycle until done=1, then enter RESP with payload=count; RUN while done=1 responds count immediately.
REQ-022 GET_COUNT, GET_STEPS SHALL respond count, steps zero-extended to 32 bits.
REQ-023 GET_STATUS SHALL respond {h[7:0] in bits 15:8, err in bit 1, done in bit 0}, other bits 0.
REQ-024 rsp_ready low in RESP SHALL stall indefinitely with payload and state unchanged.
REQ-025 Before any INIT, done SHALL read 1 so STEP/RUN are no-ops.

Reset
REQ-026 Reset low SHALL immediately force: state IDLE, rsp_valid=0, cmd_ready=1 after release, payload 0, h=0, r=0, count=0, steps=0, done=1, err=0.
REQ-027 Stack arrays (cdt/col/pos/neg, MAX_N+1 entries) SHALL be cleared on reset; reset mid-RUN abandons the search, no response issued.

Structure
REQ-028 A package nqueens_pkg SHALL hold function-ID constants, state enum, status bit positions.
REQ-029 Stack storage and the push/pop datapath SHALL be one sub-module nqueens_stack (parameter MAX_N), top holds FSM, counters, handshake.

Verification
REQ-030 INIT n=4, inputs_1=0; RUN -> response 2; GET_STATUS -> 0x00000001.
REQ-031 INIT n=8, inputs_1=0; RUN -> 92; INIT n=8, inputs_1=1; RUN -> 4.
REQ-032 INIT n=4; repeated STEP -> responses 1 until final 0; GET_COUNT -> 2; extra STEP -> 0, GET_STEPS unchanged.
REQ-033 INIT n=0 and n=MAX_N+1 -> 0xFFFFFFFF; GET_STATUS -> 0x00000003; RUN -> 0.
REQ-034 RUN n=6 with rsp_ready held low 20 cycles after rsp_valid -> payload 4 stable, cmd_ready=0 throughout; function ID 9 afterwards -> 0xFFFFFFFF.
REQ-035 Reset asserted mid-RUN n=10 -> rsp_valid=0, GET_COUNT -> 0, GET_STATUS -> 0x00000001; then INIT n=10, RUN -> 724.

Source files
------------

// File: rtl/nqueens_pkg.sv
// Shared constants for the N-Queens custom function unit: function IDs,
// controller states and the GET_STATUS bit layout.
package nqueens_pkg;

  localparam logic [9:0] FN_INIT       = 10'd0;
  localparam logic [9:0] FN_STEP       = 10'd1;
  localparam logic [9:0] FN_GET_COUNT  = 10'd2;
  localparam logic [9:0] FN_RUN        = 10'd3;
  localparam logic [9:0] FN_GET_STATUS = 10'd4;
  localparam logic [9:0] FN_GET_STEPS  = 10'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESP
  } state_t;

  localparam int STAT_DONE  = 0;
  localparam int STAT_ERR   = 1;
  localparam int STAT_H_LSB = 8;
  localparam int STAT_H_W   = 8;

  localparam logic [31:0] RSP_ERROR = 32'hFFFF_FFFF;

endpackage

// File: rtl/nqueens_stack.sv
// Backtracking stack for the bitwise N-Queens search: per-level candidate,
// column, and diagonal masks plus the current level h and open set r.
module nqueens_stack #(
  parameter  int MAX_N = 16,
  localparam int HW    = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [MAX_N-1:0] init_mask,
  input  logic [MAX_N-1:0] init_r,
  input  logic             step,
  output logic [HW-1:0]    h,
  output logic [MAX_N-1:0] r
);

  logic [MAX_N-1:0] mask_q;
  logic [MAX_N-1:0] cdt_q [MAX_N+1];
  logic [MAX_N-1:0] col_q [MAX_N+1];
  logic [MAX_N-1:0] pos_q [MAX_N+1];
  logic [MAX_N-1:0] neg_q [MAX_N+1];

  logic [MAX_N-1:0] lsb;
  logic [MAX_N-1:0] col_nx;
  logic [MAX_N-1:0] pos_nx;
  logic [MAX_N-1:0] neg_nx;

  // Next-level masks for placing a queen on the lowest open column.
  always_comb begin
    lsb    = r & (~r + MAX_N'(1));
    col_nx = col_q[h] & ~lsb;
    pos_nx = ((pos_q[h] | lsb) << 1) & mask_q;
    neg_nx = (neg_q[h] | lsb) >> 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h      <= '0;
      r      <= '0;
      mask_q <= '0;
      // NOTE: the stack is a small register array, so it takes the async
      // reset like any other state; a RAM macro could not be cleared this way.
      for (int i = 0; i <= MAX_N; i++) begin
        cdt_q[i] <= '0;
        col_q[i] <= '0;
        pos_q[i] <= '0;
        neg_q[i] <= '0;
      end
    end else if (init) begin
      h         <= '0;
      r         <= init_r;
      mask_q    <= init_mask;
      col_q[0]  <= init_mask;
      pos_q[0]  <= '0;
      neg_q[0]  <= '0;
    end else if (step) begin
      if (r != '0) begin
        cdt_q[h]            <= r & ~lsb;
        col_q[h + HW'(1)]   <= col_nx;
        pos_q[h + HW'(1)]   <= pos_nx;
        neg_q[h + HW'(1)]   <= neg_nx;
        r                   <= col_nx & ~(pos_nx | neg_nx);
        h                   <= h + HW'(1);
      end else if (h != '0) begin
        r <= cdt_q[h - HW'(1)];
        h <= h - HW'(1);
      end
    end
  end

endmodule

// File: rtl/nqueens_cfu.sv
// N-Queens solution counter behind a CFU command/response handshake:
// controller FSM, solution/step counters, and the backtracking stack.
module nqueens_cfu
  import nqueens_pkg::*;
#(
  parameter int MAX_N = 16,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int HW = $clog2(MAX_N + 1);

  state_t           state;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] steps;
  logic [HW-1:0]    n_q;

  logic [HW-1:0]    h;
  logic [MAX_N-1:0] r;

  logic             cmd_fire;
  logic             init_ok;
  logic             init_fire;
  logic [MAX_N-1:0] init_mask;
  logic [MAX_N-1:0] init_r;
  logic             kstep;
  logic             leaf;
  logic             finish;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] steps_nx;
  logic [31:0]      status_word;
  logic             unused_inputs;

  assign cmd_ready     = (state == ST_IDLE);
  assign unused_inputs = ^cmd_payload_inputs_1[31:MAX_N];

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cmd_fire  = cmd_valid && (state == ST_IDLE);
    init_ok   = (cmd_payload_inputs_0 >= 32'd1) &&
                (cmd_payload_inputs_0 <= 32'(MAX_N));
    init_mask = '0;
    for (int i = 0; i < MAX_N; i++) begin
      init_mask[i] = (cmd_payload_inputs_0 > 32'(i));
    end
    init_r = cmd_payload_inputs_1[MAX_N-1:0] & init_mask;
    if (init_r == '0) begin
      init_r = init_mask;
    end
    init_fire = cmd_fire && (cmd_payload_function_id == FN_INIT) && init_ok;

    kstep  = !done && ((cmd_fire && (cmd_payload_function_id == FN_STEP)) ||
                       (state == ST_RUN));
    leaf   = kstep && (r == '0) && (h == n_q);
    finish = kstep && (r == '0) && (h == '0);

    count_nx = (leaf && (count != '1)) ? count + CNT_W'(1) : count;
    steps_nx = (steps != '1) ? steps + CNT_W'(1) : steps;

    status_word                              = '0;
    status_word[STAT_H_LSB +: STAT_H_W]      = STAT_H_W'(h);
    status_word[STAT_ERR]                    = err;
    status_word[STAT_DONE]                   = done;
  end

  nqueens_stack #(
    .MAX_N (MAX_N)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .init      (init_fire),
    .init_mask (init_mask),
    .init_r    (init_r),
    .step      (kstep),
    .h         (h),
    .r         (r)
  );

  // NOTE: sequential state uses non-blocking assignments only; where two
  // assignments to the same register fire in one cycle, the later one wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= ST_IDLE;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      n_q                   <= '0;
      count                 <= '0;
      steps                 <= '0;
      done                  <= 1'b1;
      err                   <= 1'b0;
    end else begin
      if (kstep) begin
        count <= count_nx;
        steps <= steps_nx;
        if (finish) begin
          done <= 1'b1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            case (cmd_payload_function_id)
              FN_INIT: begin
                count <= '0;
                steps <= '0;
                if (init_ok) begin
                  n_q                   <= cmd_payload_inputs_0[HW-1:0];
                  done                  <= 1'b0;
                  err                   <= 1'b0;
                  rsp_payload_outputs_0 <= '0;
                end else begin
                  done                  <= 1'b1;
                  err                   <= 1'b1;
                  rsp_payload_outputs_0 <= RSP_ERROR;
                end
              end
              FN_STEP:       rsp_payload_outputs_0 <= {31'b0, ~(done | finish)};
              FN_GET_COUNT:  rsp_payload_outputs_0 <= 32'(count);
              FN_RUN: begin
                if (done) begin
                  rsp_payload_outputs_0 <= 32'(count);
                end else begin
                  state     <= ST_RUN;
                  rsp_valid <= 1'b0;
                end
              end
              FN_GET_STATUS: rsp_payload_outputs_0 <= status_word;
              FN_GET_STEPS:  rsp_payload_outputs_0 <= 32'(steps);
              default:       rsp_payload_outputs_0 <= RSP_ERROR;
            endcase
          end
        end
        ST_RUN: begin
          if (finish) begin
            state                 <= ST_RESP;
            rsp_valid             <= 1'b1;
            rsp_payload_outputs_0 <= 32'(count_nx);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nqueens_cfu.sv
// Self-checking bench for nqueens_cfu: directed command sequences plus random
// boards, checked against a queen-placement backtracking model.
module tb_nqueens_cfu;

  localparam int MAX_N = 16;
  localparam int CNT_W = 32;

  localparam logic [9:0] F_INIT   = 10'd0;
  localparam logic [9:0] F_STEP   = 10'd1;
  localparam logic [9:0] F_COUNT  = 10'd2;
  localparam logic [9:0] F_RUN    = 10'd3;
  localparam logic [9:0] F_STATUS = 10'd4;
  localparam logic [9:0] F_STEPS  = 10'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  nqueens_cfu #(
    .MAX_N (MAX_N),
    .CNT_W (CNT_W)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count solutions and search-tree size by placing queens row by row.
  // Each valid partial placement costs one push and, once exhausted, one
  // backtrack; the root adds a final exhausting step.
  task automatic model(input int n, input logic [31:0] sel,
                       output int sols, output int steps);
    int q[32];
    int row;
    int p;
    logic [31:0] all;
    logic [31:0] fm;
    bit ok;
    all = (32'd1 << n) - 32'd1;
    fm  = sel & all;
    if (fm == 0) fm = all;
    sols = 0;
    p    = 0;
    row  = 0;
    q[0] = -1;
    while (row >= 0) begin
      q[row]++;
      while (q[row] < n) begin
        ok = (row != 0) || fm[q[row]];
        for (int k = 0; k < row; k++) begin
          if (q[k] == q[row] || q[k] - q[row] == row - k || q[row] - q[k] == row - k)
            ok = 0;
        end
        if (ok) break;
        q[row]++;
      end
      if (q[row] >= n) begin
        row--;
      end else begin
        p++;
        if (row == n - 1) sols++;
        else begin
          row++;
          q[row] = -1;
        end
      end
    end
    steps = 2 * p + 1;
  endtask

  task automatic send(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc = 0;
    @(negedge clk);
    while (!cmd_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    fid = f;
    in0 = a;
    in1 = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int cyc = 0;
    while (!rsp_valid && cyc < 50000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic do_cmd(input string tag, input logic [9:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res);
    send(f, a, b);
    wait_rsp(tag);
    res = rsp_data;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    int sols;
    int stp;
    int n;
    logic [31:0] sel;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_payload", rsp_data, 32'd0);
    reset = 1'b1;

    // Before any INIT the unit reads done and ignores STEP/RUN.
    do_cmd("pre_status", F_STATUS, 0, 0, res); check("pre_status", res, 32'h1);
    do_cmd("pre_step", F_STEP, 0, 0, res);     check("pre_step", res, 32'd0);
    do_cmd("pre_run", F_RUN, 0, 0, res);       check("pre_run", res, 32'd0);
    do_cmd("pre_steps", F_STEPS, 0, 0, res);   check("pre_steps", res, 32'd0);

    // Four queens, full search.
    model(4, 0, sols, stp);
    do_cmd("init4", F_INIT, 4, 0, res);        check("init4", res, 32'd0);
    do_cmd("run4", F_RUN, 0, 0, res);          check("run4", res, 32'd2);
    do_cmd("status4", F_STATUS, 0, 0, res);    check("status4", res, 32'h1);
    do_cmd("steps4", F_STEPS, 0, 0, res);      check("steps4", res, 32'(stp));

    // Eight queens, full and with the first queen pinned to column 0.
    model(8, 0, sols, stp);
    do_cmd("init8", F_INIT, 8, 0, res);        check("init8", res, 32'd0);
    do_cmd("run8", F_RUN, 0, 0, res);          check("run8", res, 32'd92);
    do_cmd("steps8", F_STEPS, 0, 0, res);      check("steps8", res, 32'(stp));
    model(8, 1, sols, stp);
    do_cmd("init8m", F_INIT, 8, 1, res);       check("init8m", res, 32'd0);
    do_cmd("run8m", F_RUN, 0, 0, res);         check("run8m", res, 32'd4);
    do_cmd("steps8m", F_STEPS, 0, 0, res);     check("steps8m", res, 32'(stp));

    // Single-stepping: 1 while the search continues, 0 on the finishing step.
    model(4, 0, sols, stp);
    do_cmd("init4s", F_INIT, 4, 0, res);
    for (int k = 1; k <= stp; k++) begin
      do_cmd("step4", F_STEP, 0, 0, res);
      check($sformatf("step4_%0d", k), res, (k < stp) ? 32'd1 : 32'd0);
    end
    do_cmd("count4s", F_COUNT, 0, 0, res);     check("count4s", res, 32'd2);
    do_cmd("extra_step", F_STEP, 0, 0, res);   check("extra_step", res, 32'd0);
    do_cmd("steps4s", F_STEPS, 0, 0, res);     check("steps4s", res, 32'(stp));

    // Board-size boundaries.
    do_cmd("init_max", F_INIT, MAX_N, 0, res); check("init_max", res, 32'd0);
    do_cmd("status_max", F_STATUS, 0, 0, res); check("status_max", res, 32'h0);
    do_cmd("init0", F_INIT, 0, 0, res);        check("init0", res, 32'hFFFF_FFFF);
    do_cmd("status0", F_STATUS, 0, 0, res);    check("status0", res, 32'h3);
    do_cmd("init_big", F_INIT, MAX_N + 1, 0, res); check("init_big", res, 32'hFFFF_FFFF);
    do_cmd("status_big", F_STATUS, 0, 0, res); check("status_big", res, 32'h3);
    do_cmd("run_err", F_RUN, 0, 0, res);       check("run_err", res, 32'd0);
    do_cmd("steps_err", F_STEPS, 0, 0, res);   check("steps_err", res, 32'd0);

    // Response back-pressure on a six-queens run.
    model(6, 0, sols, stp);
    do_cmd("init6", F_INIT, 6, 0, res);
    send(F_RUN, 0, 0);
    wait_rsp("run6");
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_payload_%0d", k), rsp_data, 32'd4);
      check($sformatf("stall_ready_%0d", k), 32'(cmd_ready), 32'd0);
      check($sformatf("stall_valid_%0d", k), 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("stall_release_valid", 32'(rsp_valid), 32'd0);
    check("stall_release_ready", 32'(cmd_ready), 32'd1);
    do_cmd("bad_fid", 10'd9, 0, 0, res);       check("bad_fid", res, 32'hFFFF_FFFF);
    do_cmd("count6", F_COUNT, 0, 0, res);      check("count6", res, 32'(sols));

    // Random boards and first-row column selections.
    for (int it = 0; it < 6; it++) begin
      n   = $urandom_range(4, 7);
      sel = $urandom;
      if (it == 0) sel = 32'd0;
      model(n, sel, sols, stp);
      do_cmd("rnd_init", F_INIT, 32'(n), sel, res);
      check($sformatf("rnd_init_%0d", it), res, 32'd0);
      do_cmd("rnd_run", F_RUN, 0, 0, res);
      check($sformatf("rnd_run_n%0d_sel%h", n, sel), res, 32'(sols));
      do_cmd("rnd_steps", F_STEPS, 0, 0, res);
      check($sformatf("rnd_steps_%0d", it), res, 32'(stp));
      do_cmd("rnd_status", F_STATUS, 0, 0, res);
      check($sformatf("rnd_status_%0d", it), res, 32'h1);
    end

    // Reset in the middle of a ten-queens run.
    do_cmd("init10", F_INIT, 10, 0, res);
    send(F_RUN, 0, 0);
    repeat (300) begin
      @(posedge clk);
      #1;
    end
    check("mid_run_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_payload", rsp_data, 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    do_cmd("rst_count", F_COUNT, 0, 0, res);   check("rst_count", res, 32'd0);
    do_cmd("rst_status", F_STATUS, 0, 0, res); check("rst_status", res, 32'h1);
    do_cmd("rst_steps", F_STEPS, 0, 0, res);   check("rst_steps", res, 32'd0);
    model(10, 1, sols, stp);
    do_cmd("init10m", F_INIT, 10, 1, res);     check("init10m", res, 32'd0);
    do_cmd("run10m", F_RUN, 0, 0, res);        check("run10m", res, 32'(sols));
    do_cmd("steps10m", F_STEPS, 0, 0, res);    check("steps10m", res, 32'(stp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
